javk_mem_arbiter: RTL and testbench
===================================

# javk_mem_arbiter

Two-port memory bus arbiter for the JAVK system. It shares the single 16-bit address / 8-bit data memory port between the JAVK CPU and a DMA engine. Each access runs through a three-state sequence: arbitrate, issue, acknowledge. Grants use round-robin with a DMA lock and a CPU starvation guard. The block sits between the CPU bus pins (address bus, data bus, `rw`) and system memory.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 8, data width
- `DMA_BURST_MAX`, 16, maximum consecutive DMA grants while `cpu_req` is pending; range 1..255
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`
- `cpu_addr`  in  ADDR_W  CPU address; stable while `cpu_req`=1
- `cpu_rw`  in  1  1=read, 0=write (bus convention)
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_rdata`  out  DATA_W  CPU read data, registered; valid when `cpu_ack`=1
- `cpu_ack`  out  1  one-cycle completion pulse
- `dma_req`, `dma_addr`, `dma_rw`, `dma_wdata`, `dma_rdata`, `dma_ack`: same meaning as the CPU port
- `dma_lock`  in  1  DMA requests bus retention across accesses (burst)
- `mem_en`  out  1  memory access strobe
- `mem_addr`  out  ADDR_W  memory address
- `mem_rw`  out  1  1=read, 0=write
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  asynchronous read data; valid in the same cycle as `mem_addr`

## Operation
- States: IDLE, ISSUE, ACK. Registers: `owner` (0=CPU, 1=DMA), `last_owner`, `dma_run` (8-bit, saturating).
- IDLE behaviour:
  - Outputs: `mem_en`=0, `mem_addr`=0, `mem_rw`=1, `mem_wdata`=0.
  - If any request is present, latch the winner into `owner` and go to ISSUE.
  - Otherwise stay in IDLE.
- Winner selection in IDLE, first match wins:
  1. `cpu_req` && `dma_run`==`DMA_BURST_MAX` → CPU (starvation guard; overrides lock).
  2. `dma_req` && `dma_lock` && `last_owner`==DMA → DMA.
  3. Only one request present → that requester.
  4. Both present → the requester that is not `last_owner` (round-robin).
- ISSUE behaviour:
  - `mem_en`=1; `mem_addr`, `mem_rw` and `mem_wdata` are combinationally muxed from the owner's inputs.
  - On a read, `mem_rdata` is captured into the owner's `*_rdata` register at the edge.
  - A write commits in memory at the same edge.
  - Next state is ACK.
- ACK behaviour:
  - Owner's `*_ack`=1; the other ack stays 0; memory outputs take IDLE values.
  - `last_owner` ← `owner`.
  - `dma_run` ← `dma_run`+1 (saturate at 255) if the owner is DMA; cleared to 0 if the owner is CPU.
  - Next state is always IDLE. A requester's `req` during ACK belongs to the finished access and is never arbitrated.
- `*_rdata` holds its value until that port's next read. Writes leave `*_rdata` unchanged.
- Address and data pass through unmodified; there is no width conversion and no address arithmetic. 0xFFFF is a legal address and does not wrap.
- A request that drops before its ack is a protocol violation; the arbiter still completes and acks the latched owner.

## Timing
- Reset values: state IDLE, `owner`=0, `last_owner`=DMA (the CPU wins the first tie), `dma_run`=0, `cpu_rdata`=`dma_rdata`=0, both acks 0, `mem_en`=0, `mem_rw`=1, `mem_addr`=0, `mem_wdata`=0.
- Latency: with `req` first high in cycle N while IDLE, ISSUE is in cycle N+1 and ack is in cycle N+2.
- Throughput: one access per 3 cycles. A requester that is continuously re-requesting gets its next ISSUE 3 cycles after its previous one when uncontested.
- Reset is sampled at the edge:
  - An ISSUE cycle coinciding with `rst`=1 still commits its write, because memory sees `mem_en` before the edge.
  - No ack is produced for that access. The requester must re-request.
  - The state after the reset edge is IDLE.
- Reset during ACK: the ack pulse in that cycle is still visible; `last_owner` and `dma_run` take their reset values, not their updated values.

## Test plan
- Reset: hold `rst` 2 cycles with both requests high → after the edge, acks=0, `mem_en`=0, `mem_rw`=1, `*_rdata`=0x00; the first grant after reset release is CPU.
- CPU read: mem[0x1234]=0xA5, `cpu_req`=1, `cpu_rw`=1 at cycle N → ISSUE at N+1 with `mem_addr`=0x1234, `mem_en`=1; at N+2 `cpu_ack`=1 and `cpu_rdata`=0xA5.
- DMA write at the top address: write 0x5A to 0xFFFF → `mem_rw`=0, `mem_wdata`=0x5A in ISSUE; a following CPU read of 0xFFFF returns 0x5A with no wrap.
- Round-robin: both requests held continuously, no lock → grant order CPU, DMA, CPU, DMA, each ack 3 cycles apart.
- Lock and starvation: `DMA_BURST_MAX`=4, DMA holds the lock and requests continuously, CPU requests continuously → grant order D, D, D, D, C, D…; `dma_run` clears on the CPU grant.
- Reset in ISSUE: assert `rst` during an ISSUE for a CPU write of 0x33 to 0x0010 → mem[0x0010]=0x33, `cpu_ack` never pulses, state is IDLE next cycle.

Source files
------------

// File: rtl/javk_mem_arbiter.sv
// Shares one asynchronous-read memory port between the JAVK CPU and a DMA engine.
// Each access runs IDLE (arbitrate) -> ISSUE (memory strobe) -> ACK (completion pulse).
module javk_mem_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int DMA_BURST_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rw,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_rw,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    input  logic              dma_lock,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK} state_e;

    localparam logic       OWN_CPU   = 1'b0;
    localparam logic       OWN_DMA   = 1'b1;
    localparam logic [7:0] BURST_MAX = 8'(DMA_BURST_MAX);
    localparam logic [7:0] RUN_SAT   = 8'hFF;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [7:0]        dma_run_q, dma_run_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;

    logic              winner;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_rw;
    logic [DATA_W-1:0] sel_wdata;

    // Priority: starvation guard, then DMA lock, then single requester, then round-robin.
    always_comb begin
        winner = ~last_owner_q;
        if (cpu_req && (dma_run_q == BURST_MAX)) begin
            winner = OWN_CPU;
        end else if (dma_req && dma_lock && (last_owner_q == OWN_DMA)) begin
            winner = OWN_DMA;
        end else if (cpu_req && !dma_req) begin
            winner = OWN_CPU;
        end else if (dma_req && !cpu_req) begin
            winner = OWN_DMA;
        end
    end

    always_comb begin
        sel_addr  = (owner_q == OWN_DMA) ? dma_addr  : cpu_addr;
        sel_rw    = (owner_q == OWN_DMA) ? dma_rw    : cpu_rw;
        sel_wdata = (owner_q == OWN_DMA) ? dma_wdata : cpu_wdata;
    end

    // Memory port is driven only during ISSUE; all other states present the idle bus.
    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_rw    = 1'b1;
        mem_wdata = '0;
        if (state_q == S_ISSUE) begin
            mem_en    = 1'b1;
            mem_addr  = sel_addr;
            mem_rw    = sel_rw;
            mem_wdata = sel_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        dma_run_d    = dma_run_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        cpu_ack_d    = 1'b0;
        dma_ack_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_d = winner;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_ACK;
                if (owner_q == OWN_DMA) begin
                    dma_ack_d = 1'b1;
                    if (sel_rw) dma_rdata_d = mem_rdata;
                end else begin
                    cpu_ack_d = 1'b1;
                    if (sel_rw) cpu_rdata_d = mem_rdata;
                end
            end
            S_ACK: begin
                state_d      = S_IDLE;
                last_owner_d = owner_q;
                if (owner_q == OWN_DMA) begin
                    dma_run_d = (dma_run_q == RUN_SAT) ? RUN_SAT : dma_run_q + 8'd1;
                end else begin
                    dma_run_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A reset during ACK still lets the already-registered ack be seen for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_DMA;
            dma_run_q    <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            dma_run_q    <= dma_run_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            dma_ack_q    <= dma_ack_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;

endmodule

// File: tb/tb_javk_mem_arbiter.sv
// Random + directed bench for javk_mem_arbiter against a transaction-level timeline model.
module tb_javk_mem_arbiter;
    localparam int BURST = 4;

    bit          clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_rw, cpu_ack, dma_req, dma_rw, dma_ack, dma_lock;
    logic [15:0] cpu_addr, dma_addr, mem_addr;
    logic [7:0]  cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_rw;

    javk_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .DMA_BURST_MAX(BURST)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_rw(dma_rw), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_lock(dma_lock),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten locations read a fixed address hash; 0x1234 hashes to 0xA5.
    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h83;
    endfunction

    // Memory attached to the DUT bus.
    logic [7:0] mem [65536];
    bit         mem_vld [65536];
    assign mem_rdata = mem_vld[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    always @(posedge clk) begin
        if (mem_en && !mem_rw) begin
            mem[mem_addr]     <= mem_wdata;
            mem_vld[mem_addr] <= 1'b1;
        end
    end

    // Reference model state.
    logic [7:0]  gold [65536];
    bit          gold_vld [65536];
    int          cyc, iss_c, ack_c, free_at;
    bit          w, m_last;
    int          m_run;
    logic [15:0] w_addr;
    logic        w_rw;
    logic [7:0]  w_wd;
    logic [7:0]  exp_rd [2];
    byte         glog[$];
    int          gcyc[$];

    int checks = 0, errors = 0;
    int p_cpu, p_dma, p_lock;
    bit rnd_rst;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] gold_rd(input logic [15:0] a);
        return gold_vld[a] ? gold[a] : init_val(a);
    endfunction

    function automatic logic [15:0] rnd_addr();
        case ($urandom_range(3))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            2:       return 16'($urandom_range(15));
            default: return 16'($urandom);
        endcase
    endfunction

    // Arbitration rules from the block description, evaluated on the sampled requests.
    function automatic bit pick();
        if (cpu_req && m_run == BURST) return 1'b0;
        if (dma_req && dma_lock && m_last) return 1'b1;
        if (cpu_req != dma_req) return dma_req;
        return !m_last;
    endfunction

    task automatic model_reset(input int p);
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        m_last    = 1'b1;
        m_run     = 0;
        iss_c     = -1;
        ack_c     = -1;
        free_at   = p + 1;
    endtask

    // Effects of the clock edge that ends cycle p, using the inputs held across it.
    task automatic edge_update(input int p);
        if (p == iss_c) begin
            if (w_rw) exp_rd[w] = gold_rd(w_addr);
            else begin
                gold[w_addr]     = w_wd;
                gold_vld[w_addr] = 1'b1;
            end
        end
        if (p == ack_c) begin
            m_last = w;
            m_run  = w ? ((m_run < 255) ? m_run + 1 : 255) : 0;
        end
        if (rst) model_reset(p);
        else if (p >= free_at && (cpu_req || dma_req)) begin
            w       = pick();
            w_addr  = w ? dma_addr : cpu_addr;
            w_rw    = w ? dma_rw : cpu_rw;
            w_wd    = w ? dma_wdata : cpu_wdata;
            iss_c   = p + 1;
            ack_c   = p + 2;
            free_at = p + 3;
        end
    endtask

    task automatic step();
        bit is_iss, is_ack;
        @(negedge clk);
        edge_update(cyc);
        cyc++;
        is_iss = (cyc == iss_c);
        is_ack = (cyc == ack_c);
        chk("mem_en",    mem_en,    is_iss);
        chk("mem_addr",  mem_addr,  is_iss ? w_addr : 16'h0);
        chk("mem_rw",    mem_rw,    is_iss ? w_rw : 1'b1);
        chk("mem_wdata", mem_wdata, is_iss ? w_wd : 8'h0);
        chk("cpu_ack",   cpu_ack,   is_ack && !w);
        chk("dma_ack",   dma_ack,   is_ack && w);
        chk("cpu_rdata", cpu_rdata, exp_rd[0]);
        chk("dma_rdata", dma_rdata, exp_rd[1]);
        if (cpu_ack) begin glog.push_back("C"); gcyc.push_back(cyc); end
        if (dma_ack) begin glog.push_back("D"); gcyc.push_back(cyc); end
        if (is_ack && !w) cpu_req = 1'b0;
        if (is_ack && w)  dma_req = 1'b0;
        if (!cpu_req && $urandom_range(99) < p_cpu) begin
            cpu_req = 1'b1; cpu_addr = rnd_addr(); cpu_rw = 1'($urandom); cpu_wdata = 8'($urandom);
        end
        if (!dma_req && $urandom_range(99) < p_dma) begin
            dma_req = 1'b1; dma_addr = rnd_addr(); dma_rw = 1'($urandom); dma_wdata = 8'($urandom);
            dma_lock = ($urandom_range(99) < p_lock);
        end
        rst = rnd_rst && ($urandom_range(299) == 0);
    endtask

    task automatic drain();
        p_cpu = 0; p_dma = 0;
        for (int i = 0; i < 20 && (cpu_req || dma_req); i++) step();
        chk("drain", {cpu_req, dma_req}, 2'b00);
        step();
    endtask

    initial begin
        string lock_exp = "DDDDCD";
        int    bad = 0;
        rnd_rst = 0; p_lock = 0; p_cpu = 100; p_dma = 100;
        rst = 1'b1;
        cpu_req = 1'b1; cpu_addr = 16'h0100; cpu_rw = 1'b1; cpu_wdata = 8'h11;
        dma_req = 1'b1; dma_addr = 16'h0200; dma_rw = 1'b0; dma_wdata = 8'h22; dma_lock = 1'b0;
        repeat (2) @(negedge clk);
        cyc = 0;
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_dma_ack", dma_ack, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_rw", mem_rw, 1'b1);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("rst_dma_rdata", dma_rdata, 8'h00);
        model_reset(-1);
        rst = 1'b0;

        // Both held without lock: strict alternation starting with the CPU.
        repeat (12) step();
        chk("rr_n", glog.size(), 4);
        for (int i = 0; i < 4; i++) chk("rr_seq", (glog.size() > i) ? glog[i] : 8'h0, (i % 2) ? "D" : "C");
        chk("rr_gap", (gcyc.size() > 1) ? gcyc[1] - gcyc[0] : 0, 3);

        // Locked DMA burst broken by the starvation guard after BURST grants.
        rst = 1'b1; dma_lock = 1'b1; p_lock = 100;
        step();
        glog.delete(); gcyc.delete();
        repeat (20) step();
        chk("lock_n", glog.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++) chk("lock_seq", (glog.size() > i) ? glog[i] : 8'h0, lock_exp[i]);
        drain();

        // CPU read of preloaded 0x1234 with two-cycle latency.
        cpu_req = 1'b1; cpu_addr = 16'h1234; cpu_rw = 1'b1;
        step();
        chk("rd_en", mem_en, 1'b1);
        chk("rd_addr", mem_addr, 16'h1234);
        step();
        chk("rd_ack", cpu_ack, 1'b1);
        chk("rd_data", cpu_rdata, 8'hA5);
        step();

        // DMA write to the top address, read back by the CPU.
        dma_req = 1'b1; dma_addr = 16'hFFFF; dma_rw = 1'b0; dma_wdata = 8'h5A; dma_lock = 1'b0;
        step();
        chk("wr_rw", mem_rw, 1'b0);
        chk("wr_addr", mem_addr, 16'hFFFF);
        chk("wr_data", mem_wdata, 8'h5A);
        repeat (2) step();
        cpu_req = 1'b1; cpu_addr = 16'hFFFF; cpu_rw = 1'b1;
        repeat (2) step();
        chk("top_ack", cpu_ack, 1'b1);
        chk("top_rd", cpu_rdata, 8'h5A);
        step();

        // Reset on the ISSUE edge: write lands, no ack follows.
        cpu_req = 1'b1; cpu_addr = 16'h0010; cpu_rw = 1'b0; cpu_wdata = 8'h33;
        step();
        chk("ri_en", mem_en, 1'b1);
        rst = 1'b1; cpu_req = 1'b0;
        step();
        chk("ri_idle", mem_en, 1'b0);
        chk("ri_mem", mem_vld[16'h0010] ? mem[16'h0010] : 8'h00, 8'h33);
        for (int i = 0; i < 3; i++) begin
            chk("ri_noack", cpu_ack, 1'b0);
            step();
        end

        // Random traffic with occasional resets.
        p_cpu = 40; p_dma = 40; p_lock = 50; rnd_rst = 1;
        repeat (3000) step();
        rnd_rst = 0;
        drain();

        for (int a = 0; a < 65536; a++) begin
            if ((mem_vld[a] ? mem[a] : init_val(16'(a))) !== gold_rd(16'(a))) bad++;
        end
        chk("mem_image", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
